// File: rtl/adc_capture_sequencer_if.sv
// Host/ADC/TX-side signal bundle for adc_capture_sequencer; slave = sequencer, master = surrounding logic.
// I_* are sequencer inputs, O_* are sequencer outputs.
interface adc_capture_sequencer_if #(
   parameter int DATA_W = 12,
   parameter int CNT_W  = 16
);
   logic              I_start;
   logic              I_abort;
   logic [15:0]       I_rate_setting;
   logic [CNT_W-1:0]  I_sample_count;
   logic              I_sample_valid;
   logic [DATA_W-1:0] I_sample;
   logic              I_tx_ready;
   logic [15:0]       O_rate_setting;
   logic              O_rate_valid;
   logic              O_capture_en;
   logic              O_tx_valid;
   logic [DATA_W-1:0] O_tx_data;
   logic              O_busy;
   logic              O_done;
   logic              O_overrun;
   logic              O_timeout;

   modport master (
      output I_start, I_abort, I_rate_setting, I_sample_count, I_sample_valid, I_sample, I_tx_ready,
      input  O_rate_setting, O_rate_valid, O_capture_en, O_tx_valid, O_tx_data, O_busy, O_done,
             O_overrun, O_timeout
   );

   modport slave (
      input  I_start, I_abort, I_rate_setting, I_sample_count, I_sample_valid, I_sample, I_tx_ready,
      output O_rate_setting, O_rate_valid, O_capture_en, O_tx_valid, O_tx_data, O_busy, O_done,
             O_overrun, O_timeout
   );
endinterface

// File: rtl/adc_capture_sequencer.sv
// One ADC capture run: program rate, settle, count N samples into a 1-entry TX holding reg (drops + sticky overrun
// when TX stalls). start->rate_valid 1 cycle, sample->tx_valid 1 cycle. Define ADC_SEQ_TIMEOUT_EN for the gap watchdog.
module adc_capture_sequencer #(
   parameter int DATA_W     = 12,
   parameter int CNT_W      = 16,
   parameter int SETTLE_CYC = 64
`ifdef ADC_SEQ_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 65535
`endif
) (
   input logic                    I_clk,
   input logic                    I_rst_n,
   adc_capture_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_CONFIG, S_SETTLE, S_CAPTURE, S_DRAIN
   } state_t;

   localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   state_t            state_q, state_d;
   logic [15:0]       rate_q, rate_d;
   logic [CNT_W-1:0]  remain_q, remain_d;
   logic [SET_W-1:0]  settle_q, settle_d;
   logic              hold_vld_q, hold_vld_d;
   logic [DATA_W-1:0] hold_dat_q, hold_dat_d;
   logic              overrun_q, overrun_d;

   logic start_ok, abort_run, smp_take, last_smp, wd_expire;

   assign start_ok  = (state_q == S_IDLE) && bus.I_start && (bus.I_sample_count != '0);
   assign abort_run = (state_q != S_IDLE) && bus.I_abort;
   assign smp_take  = (state_q == S_CAPTURE) && bus.I_sample_valid && !bus.I_abort;
   assign last_smp  = smp_take && (remain_q == CNT_W'(1));

`ifdef ADC_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] wd_q, wd_d;
   logic            timeout_q, timeout_d;

   // Expires on the TIMEOUT_CYC-th consecutive CAPTURE cycle without a sample.
   assign wd_expire = (state_q == S_CAPTURE) && !bus.I_sample_valid && !bus.I_abort &&
                      (wd_q == WD_W'(TIMEOUT_CYC - 1));

   always_comb begin
      wd_d      = '0;
      timeout_d = timeout_q;
      if (start_ok)
         timeout_d = 1'b0;
      if ((state_q == S_CAPTURE) && !bus.I_sample_valid)
         wd_d = wd_q + WD_W'(1);
      if (wd_expire)
         timeout_d = 1'b1;
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
      end
   end
`else
   assign wd_expire = 1'b0;
`endif

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start_ok) state_d = S_CONFIG;
         S_CONFIG:  state_d = S_SETTLE;
         S_SETTLE:  if (settle_q == SET_W'(SETTLE_CYC - 1)) state_d = S_CAPTURE;
         S_CAPTURE: begin
            if (wd_expire)
               state_d = S_IDLE;
            else if (last_smp)
               state_d = S_DRAIN;
         end
         S_DRAIN:   if (!hold_vld_q) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
      if (abort_run)
         state_d = S_IDLE;
   end

   always_comb begin
      bus.O_rate_valid   = (state_q == S_CONFIG);
      bus.O_capture_en   = (state_q == S_CAPTURE);
      bus.O_busy         = (state_q != S_IDLE);
      bus.O_done         = (state_q == S_DRAIN) && !hold_vld_q && !bus.I_abort;
      bus.O_rate_setting = rate_q;
      bus.O_tx_valid     = hold_vld_q;
      bus.O_tx_data      = hold_dat_q;
      bus.O_overrun      = overrun_q;
`ifdef ADC_SEQ_TIMEOUT_EN
      bus.O_timeout      = timeout_q;
`else
      bus.O_timeout      = 1'b0;
`endif
   end

   always_comb begin
      rate_d     = rate_q;
      remain_d   = remain_q;
      settle_d   = '0;
      hold_vld_d = hold_vld_q;
      hold_dat_d = hold_dat_q;
      overrun_d  = overrun_q;
      if (start_ok) begin
         rate_d    = bus.I_rate_setting;
         remain_d  = bus.I_sample_count;
         overrun_d = 1'b0;
      end
      if (state_q == S_SETTLE)
         settle_d = settle_q + SET_W'(1);
      if (hold_vld_q && bus.I_tx_ready)
         hold_vld_d = 1'b0;
      // A full holding reg can still take a sample when it drains the same cycle.
      if (smp_take) begin
         remain_d = remain_q - CNT_W'(1);
         if (!hold_vld_q || bus.I_tx_ready) begin
            hold_vld_d = 1'b1;
            hold_dat_d = bus.I_sample;
         end else begin
            overrun_d = 1'b1;
         end
      end
      if (abort_run || wd_expire)
         hold_vld_d = 1'b0;
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         rate_q     <= '0;
         remain_q   <= '0;
         settle_q   <= '0;
         hold_vld_q <= 1'b0;
         hold_dat_q <= '0;
         overrun_q  <= 1'b0;
      end else begin
         rate_q     <= rate_d;
         remain_q   <= remain_d;
         settle_q   <= settle_d;
         hold_vld_q <= hold_vld_d;
         hold_dat_q <= hold_dat_d;
         overrun_q  <= overrun_d;
      end
   end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Self-checking bench for adc_capture_sequencer: vector table, directed corner sequences, random run vs model.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_adc_capture_sequencer;

   localparam int SETTLE = 4;
   localparam int TO_CYC = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   adc_capture_sequencer_if #(.DATA_W(12), .CNT_W(16)) bus ();

   adc_capture_sequencer #(
      .DATA_W(12), .CNT_W(16), .SETTLE_CYC(SETTLE)
`ifdef ADC_SEQ_TIMEOUT_EN
      , .TIMEOUT_CYC(TO_CYC)
`endif
   ) dut (
      .I_clk   (clk),
      .I_rst_n (rst_n),
      .bus     (bus)
   );

   typedef struct {
      logic        st, ab;
      logic [15:0] rate, cnt;
      logic        sv;
      logic [11:0] smp;
      logic        rdy;
      logic        e_rv, e_cen, e_busy, e_txv;
      logic [11:0] e_txd;
      logic        e_done, e_ovr;
      logic [15:0] e_rate;
   } vec_t;

   vec_t tbl[14];

   // Reference model state: phase is derived from cycles since CONFIG and samples still owed.
   bit          m_busy;
   int          m_t, m_left, m_idle;
   logic [11:0] m_pend[$];
   bit          m_ovr, m_to;
   logic [15:0] m_rate;

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chkv(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic st, input logic ab, input logic [15:0] rate, input logic [15:0] cnt,
                        input logic sv, input logic [11:0] smp, input logic rdy);
      bus.I_start        = st;
      bus.I_abort        = ab;
      bus.I_rate_setting = rate;
      bus.I_sample_count = cnt;
      bus.I_sample_valid = sv;
      bus.I_sample       = smp;
      bus.I_tx_ready     = rdy;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_busy = 0; m_t = 0; m_left = 0; m_idle = 0;
      m_pend.delete();
      m_ovr = 0; m_to = 0; m_rate = '0;
   endtask

   task automatic model_cycle();
      bit cap, drn, full;
      cap = m_busy && (m_t > SETTLE) && (m_left > 0);
      drn = m_busy && (m_t > SETTLE) && (m_left == 0);
      chk1("rnd_busy", bus.O_busy, m_busy);
      chk1("rnd_rate_valid", bus.O_rate_valid, m_busy && (m_t == 0));
      chk1("rnd_capture_en", bus.O_capture_en, cap);
      chk1("rnd_tx_valid", bus.O_tx_valid, m_pend.size() != 0);
      if (m_pend.size() != 0)
         chkv("rnd_tx_data", 16'(bus.O_tx_data), 16'(m_pend[0]));
      chk1("rnd_done", bus.O_done, drn && (m_pend.size() == 0) && !bus.I_abort);
      chk1("rnd_overrun", bus.O_overrun, m_ovr);
      chk1("rnd_timeout", bus.O_timeout, m_to);
      chkv("rnd_rate_setting", bus.O_rate_setting, m_rate);
      if (!m_busy) begin
         if (bus.I_start && (bus.I_sample_count != 0)) begin
            m_busy = 1; m_t = 0; m_idle = 0;
            m_left = int'(bus.I_sample_count);
            m_rate = bus.I_rate_setting;
            m_ovr = 0; m_to = 0;
         end
      end else if (bus.I_abort) begin
         m_busy = 0;
         m_pend.delete();
      end else if (drn && (m_pend.size() == 0)) begin
         m_busy = 0;
      end else begin
         full = (m_pend.size() != 0);
         if (full && bus.I_tx_ready)
            void'(m_pend.pop_front());
         if (cap) begin
            if (bus.I_sample_valid) begin
               m_left--;
               m_idle = 0;
               if (!full || bus.I_tx_ready)
                  m_pend.push_back(bus.I_sample);
               else
                  m_ovr = 1;
            end else begin
               m_idle++;
`ifdef ADC_SEQ_TIMEOUT_EN
               if (m_idle == TO_CYC) begin
                  m_to = 1; m_busy = 0;
                  m_pend.delete();
               end
`endif
            end
         end
         m_t++;
      end
   endtask

   initial begin
      int rdy_pct;
      // st ab rate cnt sv smp rdy | rv cen busy txv txd done ovr rate
      tbl[0]  = '{1, 0, 16'h0010, 16'd4, 0, 12'h000, 1,  0, 0, 0, 0, 12'h000, 0, 0, 16'h0000};
      tbl[1]  = '{0, 0, 16'h0000, 16'd0, 0, 12'h000, 1,  1, 0, 1, 0, 12'h000, 0, 0, 16'h0010};
      tbl[2]  = '{0, 0, 16'h0000, 16'd0, 0, 12'h000, 1,  0, 0, 1, 0, 12'h000, 0, 0, 16'h0010};
      tbl[3]  = '{0, 0, 16'h0000, 16'd0, 1, 12'hAAA, 1,  0, 0, 1, 0, 12'h000, 0, 0, 16'h0010};
      tbl[4]  = '{0, 0, 16'h0000, 16'd0, 0, 12'h000, 1,  0, 0, 1, 0, 12'h000, 0, 0, 16'h0010};
      tbl[5]  = '{0, 0, 16'h0000, 16'd0, 0, 12'h000, 1,  0, 0, 1, 0, 12'h000, 0, 0, 16'h0010};
      tbl[6]  = '{0, 0, 16'h0000, 16'd0, 1, 12'h101, 1,  0, 1, 1, 0, 12'h000, 0, 0, 16'h0010};
      tbl[7]  = '{0, 0, 16'h0000, 16'd0, 1, 12'h102, 1,  0, 1, 1, 1, 12'h101, 0, 0, 16'h0010};
      tbl[8]  = '{0, 0, 16'h0000, 16'd0, 1, 12'h103, 1,  0, 1, 1, 1, 12'h102, 0, 0, 16'h0010};
      tbl[9]  = '{0, 0, 16'h0000, 16'd0, 1, 12'h104, 1,  0, 1, 1, 1, 12'h103, 0, 0, 16'h0010};
      tbl[10] = '{0, 0, 16'h0000, 16'd0, 0, 12'h000, 1,  0, 0, 1, 1, 12'h104, 0, 0, 16'h0010};
      tbl[11] = '{0, 0, 16'h0000, 16'd0, 0, 12'h000, 1,  0, 0, 1, 0, 12'h000, 1, 0, 16'h0010};
      tbl[12] = '{1, 0, 16'hFFFF, 16'd0, 0, 12'h000, 1,  0, 0, 0, 0, 12'h000, 0, 0, 16'h0010};
      tbl[13] = '{0, 0, 16'h0000, 16'd0, 0, 12'h000, 1,  0, 0, 0, 0, 12'h000, 0, 0, 16'h0010};

      drive(0, 0, 16'h0, 16'h0, 0, 12'h0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk1("rst_busy", bus.O_busy, 0);
      chk1("rst_rate_valid", bus.O_rate_valid, 0);
      chk1("rst_capture_en", bus.O_capture_en, 0);
      chk1("rst_tx_valid", bus.O_tx_valid, 0);
      chkv("rst_tx_data", 16'(bus.O_tx_data), 16'h0);
      chk1("rst_done", bus.O_done, 0);
      chk1("rst_overrun", bus.O_overrun, 0);
      chk1("rst_timeout", bus.O_timeout, 0);
      chkv("rst_rate_setting", bus.O_rate_setting, 16'h0);
      nxt();
      rst_n = 1'b1;

      // Normal 4-sample run, a settle-time sample, then a count-0 start.
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].st, tbl[i].ab, tbl[i].rate, tbl[i].cnt, tbl[i].sv, tbl[i].smp, tbl[i].rdy);
         @(negedge clk);
         chk1($sformatf("tbl%0d_rate_valid", i), bus.O_rate_valid, tbl[i].e_rv);
         chk1($sformatf("tbl%0d_capture_en", i), bus.O_capture_en, tbl[i].e_cen);
         chk1($sformatf("tbl%0d_busy", i), bus.O_busy, tbl[i].e_busy);
         chk1($sformatf("tbl%0d_tx_valid", i), bus.O_tx_valid, tbl[i].e_txv);
         if (tbl[i].e_txv)
            chkv($sformatf("tbl%0d_tx_data", i), 16'(bus.O_tx_data), 16'(tbl[i].e_txd));
         chk1($sformatf("tbl%0d_done", i), bus.O_done, tbl[i].e_done);
         chk1($sformatf("tbl%0d_overrun", i), bus.O_overrun, tbl[i].e_ovr);
         chkv($sformatf("tbl%0d_rate_setting", i), bus.O_rate_setting, tbl[i].e_rate);
         nxt();
      end

      // TX stalled for 10 cycles from capture start: sample 1 held, 2 and 3 dropped.
      drive(1, 0, 16'h0123, 16'd3, 0, 12'h0, 0); @(negedge clk); nxt();
      drive(0, 0, 16'h0, 16'h0, 0, 12'h0, 0); @(negedge clk);
      chk1("ovr_cfg_rate_valid", bus.O_rate_valid, 1);
      chkv("ovr_cfg_rate", bus.O_rate_setting, 16'h0123);
      nxt();
      for (int i = 0; i < SETTLE; i++) begin
         drive(0, 0, 16'h0, 16'h0, 1, 12'h0F0, 0); @(negedge clk);
         chk1("ovr_settle_capture_en", bus.O_capture_en, 0);
         chk1("ovr_settle_tx_valid", bus.O_tx_valid, 0);
         nxt();
      end
      drive(0, 0, 16'h0, 16'h0, 1, 12'h111, 0); @(negedge clk);
      chk1("ovr_cap1_capture_en", bus.O_capture_en, 1);
      chk1("ovr_cap1_tx_valid", bus.O_tx_valid, 0);
      nxt();
      drive(0, 0, 16'h0, 16'h0, 1, 12'h222, 0); @(negedge clk);
      chk1("ovr_cap2_tx_valid", bus.O_tx_valid, 1);
      chkv("ovr_cap2_tx_data", 16'(bus.O_tx_data), 16'h0111);
      chk1("ovr_cap2_overrun", bus.O_overrun, 0);
      nxt();
      drive(0, 0, 16'h0, 16'h0, 1, 12'h333, 0); @(negedge clk);
      chkv("ovr_cap3_tx_data", 16'(bus.O_tx_data), 16'h0111);
      chk1("ovr_cap3_overrun", bus.O_overrun, 1);
      nxt();
      for (int i = 0; i < 7; i++) begin
         drive(0, 0, 16'h0, 16'h0, 0, 12'h0, 0); @(negedge clk);
         chk1("ovr_drain_busy", bus.O_busy, 1);
         chk1("ovr_drain_capture_en", bus.O_capture_en, 0);
         chk1("ovr_drain_tx_valid", bus.O_tx_valid, 1);
         chkv("ovr_drain_tx_data", 16'(bus.O_tx_data), 16'h0111);
         chk1("ovr_drain_done", bus.O_done, 0);
         nxt();
      end
      drive(0, 0, 16'h0, 16'h0, 0, 12'h0, 1); @(negedge clk);
      chk1("ovr_xfer_tx_valid", bus.O_tx_valid, 1);
      chkv("ovr_xfer_tx_data", 16'(bus.O_tx_data), 16'h0111);
      chk1("ovr_xfer_done", bus.O_done, 0);
      nxt();
      @(negedge clk);
      chk1("ovr_done", bus.O_done, 1);
      chk1("ovr_done_tx_valid", bus.O_tx_valid, 0);
      nxt();
      drive(0, 0, 16'h0, 16'h0, 0, 12'h0, 0); @(negedge clk);
      chk1("ovr_idle_busy", bus.O_busy, 0);
      chk1("ovr_idle_done", bus.O_done, 0);
      chk1("ovr_sticky", bus.O_overrun, 1);
      nxt();

      // Start together with abort in IDLE, then abort in SETTLE.
      drive(1, 1, 16'h0042, 16'd2, 0, 12'h0, 1); @(negedge clk);
      chk1("abs_start_overrun_kept", bus.O_overrun, 1);
      nxt();
      drive(0, 0, 16'h0, 16'h0, 0, 12'h0, 1); @(negedge clk);
      chk1("abs_cfg_rate_valid", bus.O_rate_valid, 1);
      chk1("abs_cfg_overrun_clr", bus.O_overrun, 0);
      nxt();
      drive(0, 1, 16'h0, 16'h0, 0, 12'h0, 1); @(negedge clk);
      chk1("abs_settle_busy", bus.O_busy, 1);
      nxt();
      drive(0, 0, 16'h0, 16'h0, 0, 12'h0, 1); @(negedge clk);
      chk1("abs_after_busy", bus.O_busy, 0);
      chk1("abs_after_done", bus.O_done, 0);
      chk1("abs_after_capture_en", bus.O_capture_en, 0);
      nxt();

      // Abort in CAPTURE while the holding reg is full.
      drive(1, 0, 16'h0055, 16'd3, 0, 12'h0, 0); @(negedge clk); nxt();
      drive(0, 0, 16'h0, 16'h0, 0, 12'h0, 0); @(negedge clk); nxt();
      repeat (SETTLE) begin @(negedge clk); nxt(); end
      drive(0, 0, 16'h0, 16'h0, 1, 12'h5A5, 0); @(negedge clk); nxt();
      drive(0, 0, 16'h0, 16'h0, 1, 12'h6B6, 0); @(negedge clk); nxt();
      drive(0, 1, 16'h0, 16'h0, 0, 12'h0, 0); @(negedge clk);
      chk1("abc_pre_tx_valid", bus.O_tx_valid, 1);
      chkv("abc_pre_tx_data", 16'(bus.O_tx_data), 16'h05A5);
      chk1("abc_pre_done", bus.O_done, 0);
      nxt();
      drive(0, 0, 16'h0, 16'h0, 0, 12'h0, 0); @(negedge clk);
      chk1("abc_busy", bus.O_busy, 0);
      chk1("abc_tx_valid", bus.O_tx_valid, 0);
      chk1("abc_done", bus.O_done, 0);
      chk1("abc_overrun_kept", bus.O_overrun, 1);
      nxt();

`ifdef ADC_SEQ_TIMEOUT_EN
      // Watchdog: 2 samples of 5, then 8 empty capture cycles.
      drive(1, 0, 16'h0077, 16'd5, 0, 12'h0, 0); @(negedge clk); nxt();
      drive(0, 0, 16'h0, 16'h0, 0, 12'h0, 0); @(negedge clk); nxt();
      repeat (SETTLE) begin @(negedge clk); nxt(); end
      drive(0, 0, 16'h0, 16'h0, 1, 12'h0A1, 0); @(negedge clk); nxt();
      drive(0, 0, 16'h0, 16'h0, 1, 12'h0A2, 0); @(negedge clk); nxt();
      for (int i = 0; i < TO_CYC; i++) begin
         drive(0, 0, 16'h0, 16'h0, 0, 12'h0, 0); @(negedge clk);
         chk1("to_wait_busy", bus.O_busy, 1);
         chk1("to_wait_timeout", bus.O_timeout, 0);
         chk1("to_wait_tx_valid", bus.O_tx_valid, 1);
         nxt();
      end
      @(negedge clk);
      chk1("to_busy", bus.O_busy, 0);
      chk1("to_timeout", bus.O_timeout, 1);
      chk1("to_tx_valid", bus.O_tx_valid, 0);
      chk1("to_done", bus.O_done, 0);
      nxt();
      drive(1, 0, 16'h0078, 16'd1, 0, 12'h0, 0); @(negedge clk);
      chk1("to_start_sticky", bus.O_timeout, 1);
      nxt();
      drive(0, 1, 16'h0, 16'h0, 0, 12'h0, 0); @(negedge clk);
      chk1("to_cleared", bus.O_timeout, 0);
      nxt();
      drive(0, 0, 16'h0, 16'h0, 0, 12'h0, 0);
`endif

      // Asynchronous reset in CAPTURE with a full holding reg.
      drive(1, 0, 16'h0ABC, 16'd5, 0, 12'h0, 0); @(negedge clk); nxt();
      drive(0, 0, 16'h0, 16'h0, 0, 12'h0, 0); @(negedge clk); nxt();
      repeat (SETTLE) begin @(negedge clk); nxt(); end
      drive(0, 0, 16'h0, 16'h0, 1, 12'h777, 0); @(negedge clk); nxt();
      drive(0, 0, 16'h0, 16'h0, 0, 12'h0, 0); @(negedge clk);
      chk1("arst_pre_tx_valid", bus.O_tx_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk1("arst_busy", bus.O_busy, 0);
      chk1("arst_tx_valid", bus.O_tx_valid, 0);
      chk1("arst_capture_en", bus.O_capture_en, 0);
      chkv("arst_rate_setting", bus.O_rate_setting, 16'h0);
      nxt();
      rst_n = 1'b1;

      // Randomized traffic against the reference model.
      model_reset();
      rdy_pct = 100;
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0)
            rdy_pct = (c % 600 == 0) ? 100 : ((c % 600 == 200) ? 50 : 15);
         bus.I_start        = m_busy ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) == 0);
         bus.I_sample_count = 16'($urandom_range(0, 5));
         bus.I_rate_setting = 16'($urandom);
         bus.I_abort        = ($urandom_range(0, 49) == 0);
         bus.I_sample_valid = 1'($urandom_range(0, 1));
         bus.I_sample       = 12'($urandom);
         bus.I_tx_ready     = ($urandom_range(0, 99) < rdy_pct);
         @(negedge clk);
         model_cycle();
         nxt();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
